capture_readout: RTL and testbench
==================================

Name: capture_readout

Overview:
- Read-side counterpart of the measurement capture path.
- While the system is executing, it stores incoming samples into an internal buffer of FIFO_SIZE words.
- Once capture completes, firmware drains the buffer through a valid/ready stream, in write order, with a last-word marker and a done pulse.
- Sits between the capture data path and the FW readout interface.

Parameters:
FIFO_SIZE, 1024, buffer depth in samples (power of 2, >= 4)
DATA_WIDTH, 32, sample width in bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
capture_arm  in  1  pulse: clear buffer, enter FILL
wr_data  in  DATA_WIDTH  capture sample
wr_vld  in  1  sample valid
capture_done  in  1  level: capture finished
readout_start  in  1  pulse from FW: begin draining
flush  in  1  pulse: discard contents, return to IDLE
out_data  out  DATA_WIDTH  readout sample
out_vld  out  1  readout valid
out_ready  in  1  FW accepts sample
out_last  out  1  qualifies final word (with out_vld)
readout_done  out  1  one-cycle pulse after last handshake
word_count  out  $clog2(FIFO_SIZE)+1  samples stored
busy  out  1  state is not IDLE
event_wr_when_not_filling  out  1  one-cycle pulse
event_overflow  out  1  one-cycle pulse
event_readout_start_when_not_ready  out  1  one-cycle pulse

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, pointers=0, word_count=0, all outputs 0. Reset mid-readout aborts with no done pulse.
- States: IDLE, FILL, READY, DRAIN, DONE.
- IDLE -> FILL on capture_arm.
  - Write pointer and word_count clear.
- FILL: each wr_vld writes wr_data at wr_ptr; wr_ptr and word_count increment.
  - wr_vld with word_count==FIFO_SIZE: write dropped, event_overflow pulses.
  - FILL -> READY when capture_done=1 or word_count reaches FIFO_SIZE.
  - A wr_vld in the transition cycle is still written if space remains.
- READY -> DRAIN on readout_start.
  - If word_count==0: go straight to DONE and pulse readout_done one cycle later.
- DRAIN: memory read is synchronous, 1-cycle latency.
  - readout_start at posedge t gives out_vld=1 from cycle t+2.
  - Output register plus one-entry skid: out_data is stable while out_vld=1 and out_ready=0.
  - With out_ready held high: one word per cycle, no bubbles.
  - out_last=1 on the word with index word_count-1.
  - Handshake on last word: DRAIN -> DONE, out_vld drops next cycle, readout_done pulses in the DONE-entry cycle.
- DONE -> READY automatically after one cycle.
  - Contents are retained, so readout_start re-drains the same data (redo readout).
  - capture_arm in READY starts a new capture.
- flush in any state: -> IDLE next cycle, word_count=0, out_vld=0. flush wins over all simultaneous inputs.
- Event pulses:
  - event_wr_when_not_filling: wr_vld outside FILL; the data is ignored.
  - event_readout_start_when_not_ready: readout_start outside READY; ignored.
- capture_arm in FILL: restarts the fill (pointers cleared).
- capture_arm in DRAIN: ignored.
- Read pointer wraps naturally at FIFO_SIZE; word_count saturates at FIFO_SIZE.
- No X on out_data when out_vld=0; out_data holds its last value.

Test Plan:
1. Full fill then drain:
   - Stimulus: capture_arm, then 1024 wr_vld samples 0..1023, then readout_start, out_ready=1.
   - Response: state reaches READY with no capture_done; word_count=1024; out_vld first at t+2; 1024 consecutive words 0..1023; out_last on 1023; readout_done pulses once.
2. Partial capture with backpressure:
   - Stimulus: 5 samples A0..A4, capture_done, readout_start, out_ready toggling 1,0,0,1,...
   - Response: 5 words in order; out_data unchanged during ready-low cycles; out_last only with A4.
3. Overflow:
   - Stimulus: after 1024 samples in the same cycle as the transition, one extra wr_vld.
   - Response: event_overflow pulses; word_count stays 1024; the extra word never appears on readout.
4. Misuse events:
   - Stimulus: readout_start in FILL; wr_vld in READY.
   - Response: each corresponding event pulses exactly one cycle; state and word_count unchanged.
5. Redo and flush:
   - Stimulus: after readout_done, readout_start again; then assert flush mid-drain at word 3.
   - Response: the second drain repeats the identical sequence; after flush, out_vld=0 next cycle, state IDLE, word_count=0, no readout_done.
6. Zero-length and reset:
   - Stimulus: capture_arm, capture_done with no samples, readout_start; separately, rst mid-DRAIN.
   - Response: readout_done pulses with out_vld never high; after rst, all outputs 0 and busy=0.

Source files
------------

// File: rtl/capture_readout.sv
// Capture buffer with streaming readout: fills from the capture path while
// executing, then drains to firmware in write order over valid/ready with a
// last-word marker and a done pulse.
module capture_readout #(
  parameter int unsigned FIFO_SIZE  = 1024,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_capture_arm,
  input  logic [DATA_WIDTH-1:0]       i_wr_data,
  input  logic                        i_wr_vld,
  input  logic                        i_capture_done,
  input  logic                        i_readout_start,
  input  logic                        i_flush,
  output logic [DATA_WIDTH-1:0]       o_out_data,
  output logic                        o_out_vld,
  input  logic                        i_out_ready,
  output logic                        o_out_last,
  output logic                        o_readout_done,
  output logic [$clog2(FIFO_SIZE):0]  o_word_count,
  output logic                        o_busy,
  output logic                        o_event_wr_when_not_filling,
  output logic                        o_event_overflow,
  output logic                        o_event_readout_start_when_not_ready
);

  localparam int unsigned AW = $clog2(FIFO_SIZE);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_SIZE);

  typedef enum logic [2:0] {StIdle, StFill, StReady, StDrain, StDone} state_t;

  state_t                r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_SIZE];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_word_count, r_issued;

  // Read pipeline: synchronous memory read stage, output register, skid entry
  logic                  r_rd_vld, r_rd_last;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_out_vld, r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_skid_vld, r_skid_last;
  logic [DATA_WIDTH-1:0] r_skid_data;

  logic r_readout_done, r_ev_wr_nf, r_ev_ovf, r_ev_rs_nr;

  logic       w_clear_fill, w_wr_en, w_start_drain, w_pop, w_issue, w_room;
  logic [1:0] w_occ;

  // Datapath strobes derived from state and inputs; flush overrides everything
  always_comb begin
    w_clear_fill  = !i_flush && i_capture_arm &&
                    (r_state == StIdle || r_state == StFill || r_state == StReady);
    w_wr_en       = !i_flush && (r_state == StFill) && !i_capture_arm && i_wr_vld &&
                    (r_word_count != FULL);
    w_start_drain = !i_flush && (r_state == StReady) && !i_capture_arm && i_readout_start &&
                    (r_word_count != '0);
    w_pop         = r_out_vld && i_out_ready;
    // Words held or in flight never exceed the two downstream slots
    w_occ         = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_vld};
    w_room        = (w_occ - {1'b0, w_pop}) < 2'd2;
    w_issue       = !i_flush && (r_state == StDrain) && (r_issued != r_word_count) && w_room;
  end

  // Next-state decode
  always_comb begin
    w_state_d = r_state;
    if (i_flush) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (i_capture_arm) w_state_d = StFill;
        StFill: begin
          if (i_capture_arm) w_state_d = StFill;
          else if (i_capture_done || r_word_count == FULL) w_state_d = StReady;
        end
        StReady: begin
          if (i_capture_arm) w_state_d = StFill;
          else if (i_readout_start) w_state_d = (r_word_count == '0) ? StDone : StDrain;
        end
        StDrain: if (w_pop && r_out_last) w_state_d = StDrain == StDrain ? StDone : StDrain;
        StDone:  w_state_d = StReady;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Sample storage and synchronous read port
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
    if (w_issue) r_rd_data <= r_mem[r_rd_ptr];
  end

  // State, pointers, readout pipeline and event pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_word_count   <= '0;
      r_issued       <= '0;
      r_rd_vld       <= 1'b0;
      r_rd_last      <= 1'b0;
      r_out_vld      <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_data     <= '0;
      r_skid_vld     <= 1'b0;
      r_skid_last    <= 1'b0;
      r_skid_data    <= '0;
      r_readout_done <= 1'b0;
      r_ev_wr_nf     <= 1'b0;
      r_ev_ovf       <= 1'b0;
      r_ev_rs_nr     <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_readout_done <= (w_state_d == StDone);
      r_ev_wr_nf     <= !i_flush && i_wr_vld && (r_state != StFill);
      r_ev_ovf       <= !i_flush && (r_state == StFill) && !i_capture_arm && i_wr_vld &&
                        (r_word_count == FULL);
      r_ev_rs_nr     <= !i_flush && i_readout_start && (r_state != StReady);

      if (i_flush || w_clear_fill) begin
        r_wr_ptr     <= '0;
        r_word_count <= '0;
      end else if (w_wr_en) begin
        r_wr_ptr     <= r_wr_ptr + 1'b1;
        r_word_count <= r_word_count + 1'b1;
      end

      if (i_flush || w_start_drain || r_state != StDrain) begin
        r_rd_vld   <= 1'b0;
        r_skid_vld <= 1'b0;
        r_out_vld  <= 1'b0;
        if (i_flush || w_start_drain) begin
          r_rd_ptr <= '0;
          r_issued <= '0;
        end
      end else begin
        r_rd_vld  <= w_issue;
        r_rd_last <= w_issue && (r_issued == r_word_count - CW'(1));
        if (w_issue) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_issued <= r_issued + 1'b1;
        end
        if (!r_out_vld || w_pop) begin
          // Output slot frees up: refill from skid first to keep order
          if (r_skid_vld) begin
            r_out_vld  <= 1'b1;
            r_out_data <= r_skid_data;
            r_out_last <= r_skid_last;
            r_skid_vld <= r_rd_vld;
            if (r_rd_vld) begin
              r_skid_data <= r_rd_data;
              r_skid_last <= r_rd_last;
            end
          end else if (r_rd_vld) begin
            r_out_vld  <= 1'b1;
            r_out_data <= r_rd_data;
            r_out_last <= r_rd_last;
          end else begin
            r_out_vld <= 1'b0;
          end
        end else if (r_rd_vld) begin
          r_skid_vld  <= 1'b1;
          r_skid_data <= r_rd_data;
          r_skid_last <= r_rd_last;
        end
      end
    end
  end

  assign o_out_data                          = r_out_data;
  assign o_out_vld                           = r_out_vld;
  assign o_out_last                          = r_out_last && r_out_vld;
  assign o_readout_done                      = r_readout_done;
  assign o_word_count                        = r_word_count;
  assign o_busy                              = (r_state != StIdle);
  assign o_event_wr_when_not_filling         = r_ev_wr_nf;
  assign o_event_overflow                    = r_ev_ovf;
  assign o_event_readout_start_when_not_ready = r_ev_rs_nr;

endmodule

// File: tb/tb_capture_readout.sv
// Directed bench for capture_readout: fill/drain, backpressure, overflow,
// misuse events, redo, flush, zero-length capture and reset mid-drain.
module tb_capture_readout;

  localparam int unsigned FS = 1024;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst, capture_arm, wr_vld, capture_done, readout_start, flush, out_ready;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] out_data;
  logic          out_vld, out_last, readout_done, busy;
  logic          ev_wr, ev_ovf, ev_rs;
  logic [10:0]   word_count;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [DW-1:0] exp_words [FS];

  capture_readout #(.FIFO_SIZE(FS), .DATA_WIDTH(DW)) dut (
    .i_clk                                (clk),
    .i_rst                                (rst),
    .i_capture_arm                        (capture_arm),
    .i_wr_data                            (wr_data),
    .i_wr_vld                             (wr_vld),
    .i_capture_done                       (capture_done),
    .i_readout_start                      (readout_start),
    .i_flush                              (flush),
    .o_out_data                           (out_data),
    .o_out_vld                            (out_vld),
    .i_out_ready                          (out_ready),
    .o_out_last                           (out_last),
    .o_readout_done                       (readout_done),
    .o_word_count                         (word_count),
    .o_busy                               (busy),
    .o_event_wr_when_not_filling          (ev_wr),
    .o_event_overflow                     (ev_ovf),
    .o_event_readout_start_when_not_ready (ev_rs)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"},  out_data, 0);
    check({tag, "_vld"},   out_vld, 0);
    check({tag, "_last"},  out_last, 0);
    check({tag, "_done"},  readout_done, 0);
    check({tag, "_count"}, word_count, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_evwr"},  ev_wr, 0);
    check({tag, "_evovf"}, ev_ovf, 0);
    check({tag, "_evrs"},  ev_rs, 0);
  endtask

  // Full-rate drain of n words from READY; expects exp_words[0..n-1]
  task automatic drain_all(input int n);
    out_ready = 1'b1;
    readout_start = 1'b1;
    tick();
    readout_start = 1'b0;
    check("lat_t0_vld", out_vld, 0);
    check("start_in_ready_ev", ev_rs, 0);
    tick();
    check("lat_t1_vld", out_vld, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      check("drain_vld", out_vld, 1);
      check("drain_data", out_data, exp_words[i]);
      check("drain_last", out_last, (i == n - 1));
      check("drain_done_early", readout_done, 0);
      tick();
    end
    check("drain_done_pulse", readout_done, 1);
    check("drain_vld_after", out_vld, 0);
    tick();
    check("drain_done_once", readout_done, 0);
    check("drain_back_ready", busy, 1);
  endtask

  initial begin
    int   k;
    logic hs, held;
    logic [DW-1:0] prev;

    rst = 1'b1; capture_arm = 0; wr_vld = 0; capture_done = 0; readout_start = 0;
    flush = 0; out_ready = 0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Full fill without capture_done, overflow in the transition cycle, drain
    capture_arm = 1'b1; tick(); capture_arm = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_count", word_count, 0);
    for (int i = 0; i < FS; i++) begin
      wr_data = DW'(i); wr_vld = 1'b1; exp_words[i] = DW'(i);
      tick();
    end
    check("full_count", word_count, FS);
    wr_data = 32'hDEAD_BEEF;
    tick();
    wr_vld = 1'b0;
    check("ovf_pulse", ev_ovf, 1);
    check("ovf_count", word_count, FS);
    check("ovf_not_wrnf", ev_wr, 0);
    tick();
    check("ovf_one_cycle", ev_ovf, 0);
    drain_all(FS);

    // Redo readout of the same contents
    drain_all(FS);

    // Partial capture with a misuse readout_start mid-fill
    capture_arm = 1'b1; tick(); capture_arm = 1'b0;
    check("rearm_count", word_count, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        wr_vld = 1'b0; readout_start = 1'b1;
        tick();
        readout_start = 1'b0;
        check("rs_in_fill_ev", ev_rs, 1);
        check("rs_in_fill_count", word_count, 2);
        tick();
        check("rs_in_fill_once", ev_rs, 0);
      end
      wr_data = 32'hA0A0_0000 + DW'(i); wr_vld = 1'b1; exp_words[i] = wr_data;
      tick();
    end
    wr_vld = 1'b0; capture_done = 1'b1;
    tick();
    capture_done = 1'b0;
    check("partial_count", word_count, 5);
    wr_data = 32'hFFFF_FFFF; wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0;
    check("wr_in_ready_ev", ev_wr, 1);
    check("wr_in_ready_count", word_count, 5);
    check("wr_in_ready_ovf", ev_ovf, 0);
    tick();
    check("wr_in_ready_once", ev_wr, 0);

    // Backpressure drain with out_ready pattern 1,0,0 repeating
    readout_start = 1'b1; tick(); readout_start = 1'b0;
    k = 0; held = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = (cyc % 3 == 0);
      if (held) begin
        check("bp_hold_vld", out_vld, 1);
        check("bp_hold_data", out_data, prev);
      end
      if (out_vld) begin
        check("bp_data", out_data, exp_words[k]);
        check("bp_last", out_last, (k == 4));
      end
      hs   = out_vld && out_ready;
      held = out_vld && !out_ready;
      prev = out_data;
      tick();
      if (hs) k++;
      if (hs && k == 5) begin
        check("bp_done_pulse", readout_done, 1);
        check("bp_vld_drop", out_vld, 0);
        break;
      end
      check("bp_done_early", readout_done, 0);
    end
    check("bp_word_total", k, 5);
    tick();
    check("bp_done_once", readout_done, 0);

    // Redo then flush while word 3 is presented
    drain_all(5);
    out_ready = 1'b1; readout_start = 1'b1; tick(); readout_start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check("fl_data", out_data, exp_words[i]);
      tick();
    end
    check("fl_word3", out_data, exp_words[3]);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_vld", out_vld, 0);
    check("fl_busy", busy, 0);
    check("fl_count", word_count, 0);
    check("fl_no_done", readout_done, 0);
    tick();
    check("fl_no_done_later", readout_done, 0);
    check("fl_vld_later", out_vld, 0);

    // Zero-length capture
    capture_arm = 1'b1; tick(); capture_arm = 1'b0;
    capture_done = 1'b1; tick(); capture_done = 1'b0;
    check("zero_count", word_count, 0);
    readout_start = 1'b1; tick(); readout_start = 1'b0;
    check("zero_done", readout_done, 1);
    check("zero_vld", out_vld, 0);
    tick();
    check("zero_done_once", readout_done, 0);
    check("zero_vld_after", out_vld, 0);

    // Reset mid-drain
    capture_arm = 1'b1; tick(); capture_arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'h5500_0000 + DW'(i); wr_vld = 1'b1; tick();
    end
    wr_vld = 1'b0; capture_done = 1'b1; tick(); capture_done = 1'b0;
    out_ready = 1'b0; readout_start = 1'b1; tick(); readout_start = 1'b0;
    tick(); tick();
    check("rstd_vld", out_vld, 1);
    check("rstd_data", out_data, 32'h5500_0000);
    rst = 1'b1; tick(); rst = 1'b0;
    check_idle_outputs("rst_mid");
    out_ready = 1'b1;
    tick(); tick();
    check("rst_mid_no_done", readout_done, 0);
    check("rst_mid_no_vld", out_vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
